// File: rtl/uart_fifo_access_ctrl.sv
// Sequencing controller in front of the UART receive FIFO: buffers one received byte,
// arbitrates host/loopback reads round-robin and emits spaced single-cycle FIFO strobes.
module uart_fifo_access_ctrl #(
    parameter int DATA_BITS   = 8,
    parameter int INIT_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] Rx_Data,
    input  logic                 Rx_Valid,
    input  logic                 Host_Rd_Req,
    input  logic                 Loop_Rd_Req,
    input  logic                 BIST_Mode,
    input  logic                 Drop_Clr,
    input  logic                 FIFO_Empty,
    input  logic                 FIFO_Overflow,
    input  logic [DATA_BITS-1:0] FIFO_Data_Out,
    output logic [DATA_BITS-1:0] FIFO_Wr_Data,
    output logic                 FIFO_Data_Rdy,
    output logic                 FIFO_Pop_Data,
    output logic [DATA_BITS-1:0] Rd_Data,
    output logic                 Host_Rd_Ack,
    output logic                 Loop_Rd_Ack,
    output logic                 Rx_Drop,
    output logic                 Busy
);
    localparam int CNT_W = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;

    typedef enum logic [2:0] {
        S_INIT, S_IDLE, S_WR_STB, S_RD_STB, S_GAP, S_RD_CAP
    } state_t;

    state_t               r_state;
    logic [CNT_W-1:0]     r_init_cnt;
    logic [DATA_BITS-1:0] r_hold_data;
    logic                 r_hold_valid;
    logic                 r_drop;
    logic                 r_ptr;
    logic                 r_grant;
    logic                 r_last_rd;
    logic                 r_data_rdy;
    logic                 r_pop;
    logic                 r_host_ack;
    logic                 r_loop_ack;
    logic [DATA_BITS-1:0] r_rd_data;

    logic w_host_req;
    logic w_loop_req;
    logic w_grant_loop;
    logic w_discard;
    logic w_capture;
    logic w_drop_new;

    // A requester is ignored in the cycle its Ack is presented, so a still-held level is not re-served.
    assign w_host_req   = Host_Rd_Req & ~r_host_ack;
    assign w_loop_req   = Loop_Rd_Req & ~r_loop_ack;
    assign w_grant_loop = w_loop_req & (~w_host_req | r_ptr);
    assign w_discard    = (r_state == S_IDLE) & r_hold_valid & ~BIST_Mode & FIFO_Overflow;
    assign w_capture    = Rx_Valid & (~r_hold_valid | (r_state == S_WR_STB));
    assign w_drop_new   = Rx_Valid & ~w_capture;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hold_data  <= '0;
            r_hold_valid <= 1'b0;
            r_drop       <= 1'b0;
        end else begin
            if (w_capture) begin
                r_hold_data  <= Rx_Data;
                r_hold_valid <= 1'b1;
            end else if ((r_state == S_WR_STB) || w_discard) begin
                r_hold_valid <= 1'b0;
            end
            if (w_drop_new || w_discard) begin
                r_drop <= 1'b1;
            end else if (Drop_Clr) begin
                r_drop <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_INIT;
            r_init_cnt <= '0;
            r_ptr      <= 1'b0;
            r_grant    <= 1'b0;
            r_last_rd  <= 1'b0;
            r_data_rdy <= 1'b0;
            r_pop      <= 1'b0;
            r_host_ack <= 1'b0;
            r_loop_ack <= 1'b0;
            r_rd_data  <= '0;
        end else begin
            r_data_rdy <= 1'b0;
            r_pop      <= 1'b0;
            r_host_ack <= 1'b0;
            r_loop_ack <= 1'b0;
            case (r_state)
                S_INIT: begin
                    if (r_init_cnt == CNT_W'(INIT_CYCLES - 1)) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_init_cnt <= r_init_cnt + 1'b1;
                    end
                end
                S_IDLE: begin
                    // Writes win over reads: the receiver has no way to stall.
                    if (w_discard) begin
                        r_state <= S_IDLE;
                    end else if (r_hold_valid && !BIST_Mode) begin
                        r_state    <= S_WR_STB;
                        r_data_rdy <= 1'b1;
                        r_last_rd  <= 1'b0;
                    end else if ((w_host_req || w_loop_req) && !BIST_Mode && !FIFO_Empty) begin
                        r_state   <= S_RD_STB;
                        r_pop     <= 1'b1;
                        r_grant   <= w_grant_loop;
                        r_last_rd <= 1'b1;
                    end
                end
                S_WR_STB: r_state <= S_GAP;
                S_RD_STB: r_state <= S_GAP;
                S_GAP:    r_state <= r_last_rd ? S_RD_CAP : S_IDLE;
                S_RD_CAP: begin
                    r_rd_data  <= FIFO_Data_Out;
                    r_host_ack <= ~r_grant;
                    r_loop_ack <= r_grant;
                    r_ptr      <= ~r_grant;
                    r_state    <= S_IDLE;
                end
                default:  r_state <= S_INIT;
            endcase
        end
    end

    assign FIFO_Wr_Data  = r_hold_data;
    assign FIFO_Data_Rdy = r_data_rdy;
    assign FIFO_Pop_Data = r_pop;
    assign Rd_Data       = r_rd_data;
    assign Host_Rd_Ack   = r_host_ack;
    assign Loop_Rd_Ack   = r_loop_ack;
    assign Rx_Drop       = r_drop;
    assign Busy          = (r_state != S_IDLE) | r_hold_valid;
endmodule

// File: tb/tb_uart_fifo_access_ctrl.sv
// Bench for uart_fifo_access_ctrl: cycle table, directed corner sequences and a
// randomized run scored against a queue-based FIFO/holding-register model.
module tb_uart_fifo_access_ctrl;
    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] Rx_Data;
    logic       Rx_Valid;
    logic       Host_Rd_Req;
    logic       Loop_Rd_Req;
    logic       BIST_Mode;
    logic       Drop_Clr;
    logic       FIFO_Empty;
    logic       FIFO_Overflow;
    logic [7:0] FIFO_Data_Out;
    logic [7:0] FIFO_Wr_Data;
    logic       FIFO_Data_Rdy;
    logic       FIFO_Pop_Data;
    logic [7:0] Rd_Data;
    logic       Host_Rd_Ack;
    logic       Loop_Rd_Ack;
    logic       Rx_Drop;
    logic       Busy;

    uart_fifo_access_ctrl #(.DATA_BITS(8), .INIT_CYCLES(2)) dut (
        .clk(clk), .rst(rst), .Rx_Data(Rx_Data), .Rx_Valid(Rx_Valid),
        .Host_Rd_Req(Host_Rd_Req), .Loop_Rd_Req(Loop_Rd_Req), .BIST_Mode(BIST_Mode),
        .Drop_Clr(Drop_Clr), .FIFO_Empty(FIFO_Empty), .FIFO_Overflow(FIFO_Overflow),
        .FIFO_Data_Out(FIFO_Data_Out), .FIFO_Wr_Data(FIFO_Wr_Data),
        .FIFO_Data_Rdy(FIFO_Data_Rdy), .FIFO_Pop_Data(FIFO_Pop_Data), .Rd_Data(Rd_Data),
        .Host_Rd_Ack(Host_Rd_Ack), .Loop_Rd_Ack(Loop_Rd_Ack), .Rx_Drop(Rx_Drop), .Busy(Busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // FIFO contents and scoreboards
    logic [7:0] fq[$];
    logic [7:0] exp_wr[$];
    logic [7:0] exp_rd[$];
    logic [7:0] dout_next;
    logic       m_drop;
    logic       sb_on;
    logic       auto_drop;
    logic       prev_strobe;

    logic       s_rdy, s_pop, s_hack, s_lack, s_busy, s_drop;
    logic [7:0] s_wr, s_rd;

    typedef struct packed {
        logic       rxv;
        logic [7:0] rxd;
        logic       hreq;
        logic       lreq;
        logic [4:0] flags;   // {rdy, pop, host_ack, loop_ack, busy}
        logic [7:0] data;
    } vec_t;
    vec_t tbl[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic fifo_push(input logic [7:0] b);
        fq.push_back(b);
        FIFO_Empty = 1'b0;
    endtask

    // One clock cycle: sample at the falling edge, update models, realign 1 after the rising edge.
    task automatic step();
        logic drop_ev;
        @(negedge clk);
        s_rdy = FIFO_Data_Rdy; s_pop = FIFO_Pop_Data; s_hack = Host_Rd_Ack;
        s_lack = Loop_Rd_Ack; s_busy = Busy; s_drop = Rx_Drop;
        s_wr = FIFO_Wr_Data; s_rd = Rd_Data;
        chk("strobe_exclusive", 32'(s_rdy & s_pop), 0);
        chk("strobe_spacing", 32'(prev_strobe & (s_rdy | s_pop)), 0);
        prev_strobe = s_rdy | s_pop;
        if (s_rdy) fq.push_back(s_wr);
        if (s_pop) begin
            chk("pop_nonempty", 32'(fq.size() > 0), 1);
            if (fq.size() > 0) dout_next = fq.pop_front();
            if (sb_on) exp_rd.push_back(dout_next);
        end
        if (sb_on) begin
            if (s_rdy) begin
                chk("wr_expected", 32'(exp_wr.size()), 1);
                if (exp_wr.size() > 0) chk("wr_data", 32'(s_wr), 32'(exp_wr.pop_front()));
            end
            chk("rx_drop", 32'(s_drop), 32'(m_drop));
            drop_ev = 1'b0;
            if (Rx_Valid) begin
                if (exp_wr.size() == 0) exp_wr.push_back(Rx_Data);
                else drop_ev = 1'b1;
            end
            if (drop_ev) m_drop = 1'b1;
            else if (Drop_Clr) m_drop = 1'b0;
            chk("single_ack", 32'(s_hack & s_lack), 0);
            if (s_hack) chk("host_ack_req", 32'(Host_Rd_Req), 1);
            if (s_lack) chk("loop_ack_req", 32'(Loop_Rd_Req), 1);
            if (s_hack | s_lack) begin
                chk("rd_pending", 32'(exp_rd.size() > 0), 1);
                if (exp_rd.size() > 0) chk("rd_data", 32'(s_rd), 32'(exp_rd.pop_front()));
            end
        end
        @(posedge clk);
        #1;
        FIFO_Data_Out = dout_next;
        FIFO_Empty = (fq.size() == 0);
        if (auto_drop && s_hack) Host_Rd_Req = 1'b0;
        if (auto_drop && s_lack) Loop_Rd_Req = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        Rx_Valid = 1'b0; Rx_Data = 8'h00; Host_Rd_Req = 1'b0; Loop_Rd_Req = 1'b0;
        BIST_Mode = 1'b0; Drop_Clr = 1'b0; FIFO_Overflow = 1'b0;
        fq.delete(); exp_wr.delete(); exp_rd.delete();
        dout_next = 8'h00; FIFO_Data_Out = 8'h00; FIFO_Empty = 1'b1;
        prev_strobe = 1'b0; m_drop = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_flags", 32'({FIFO_Data_Rdy, FIFO_Pop_Data, Host_Rd_Ack, Loop_Rd_Ack, Rx_Drop, Busy}), 32'h01);
        chk("reset_data", 32'({FIFO_Wr_Data, Rd_Data}), 0);
        rst = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        int idx, rdy_i, pop_i, hack_i, n, cnt, cnt2;
        logic [7:0] d, wr;
        logic       found;
        logic [5:0] pv, hv, lv;
        logic       who[3];
        logic [7:0] dat[3];

        // cycle 0 is the first cycle after reset release
        tbl[0]  = '{1'b1, 8'hA5, 1'b0, 1'b0, 5'b00001, 8'h00};
        tbl[1]  = '{1'b0, 8'h00, 1'b0, 1'b0, 5'b00001, 8'h00};
        tbl[2]  = '{1'b0, 8'h00, 1'b0, 1'b0, 5'b00001, 8'h00};
        tbl[3]  = '{1'b0, 8'h00, 1'b0, 1'b0, 5'b10001, 8'hA5};
        tbl[4]  = '{1'b0, 8'h00, 1'b0, 1'b0, 5'b00001, 8'h00};
        tbl[5]  = '{1'b0, 8'h00, 1'b1, 1'b0, 5'b00000, 8'h00};
        tbl[6]  = '{1'b0, 8'h00, 1'b1, 1'b0, 5'b01001, 8'h00};
        tbl[7]  = '{1'b0, 8'h00, 1'b1, 1'b0, 5'b00001, 8'h00};
        tbl[8]  = '{1'b0, 8'h00, 1'b1, 1'b0, 5'b00001, 8'h00};
        tbl[9]  = '{1'b0, 8'h00, 1'b1, 1'b0, 5'b00100, 8'hA5};
        tbl[10] = '{1'b0, 8'h00, 1'b0, 1'b0, 5'b00000, 8'h00};

        sb_on = 1'b0; auto_drop = 1'b1;
        do_reset();

        for (int i = 0; i < 11; i++) begin
            Rx_Valid = tbl[i].rxv; Rx_Data = tbl[i].rxd;
            Host_Rd_Req = tbl[i].hreq; Loop_Rd_Req = tbl[i].lreq;
            step();
            chk($sformatf("tbl_flags_c%0d", i), 32'({s_rdy, s_pop, s_hack, s_lack, s_busy}), 32'(tbl[i].flags));
            if (tbl[i].flags[4]) chk($sformatf("tbl_wr_c%0d", i), 32'(s_wr), 32'(tbl[i].data));
            if (tbl[i].flags[2] | tbl[i].flags[1]) chk($sformatf("tbl_rd_c%0d", i), 32'(s_rd), 32'(tbl[i].data));
        end

        // Host read of 0x3C: pop in T+1, Ack in T+4
        fifo_push(8'h3C); Host_Rd_Req = 1'b1;
        pv = '0; hv = '0; lv = '0; d = 8'h00;
        for (int k = 0; k < 6; k++) begin
            step();
            pv[k] = s_pop; hv[k] = s_hack; lv[k] = s_lack;
            if (s_hack) d = s_rd;
        end
        chk("host_pop_timing", 32'(pv), 32'h02);
        chk("host_ack_timing", 32'(hv), 32'h10);
        chk("host_no_loop_ack", 32'(lv), 0);
        chk("host_rd_data", 32'(d), 32'h3C);

        // Empty FIFO holds off a loopback request
        Loop_Rd_Req = 1'b1; cnt = 0;
        for (int k = 0; k < 20; k++) begin
            step();
            cnt += int'(s_pop) + int'(s_lack);
        end
        chk("empty_no_service", 32'(cnt), 0);
        fifo_push(8'h77); idx = -1; d = 8'h00;
        for (int k = 0; k < 10; k++) begin
            step();
            if (s_lack && idx < 0) begin idx = k; d = s_rd; end
        end
        chk("empty_serve_latency", 32'(idx), 4);
        chk("empty_serve_data", 32'(d), 32'h77);

        // Overflow discards the held byte
        FIFO_Overflow = 1'b1; Rx_Valid = 1'b1; Rx_Data = 8'h55;
        step();
        Rx_Valid = 1'b0; cnt = 0;
        for (int k = 0; k < 5; k++) begin
            step();
            cnt += int'(s_rdy);
        end
        chk("ovf_no_write", 32'(cnt), 0);
        chk("ovf_drop_set", 32'(s_drop), 1);
        chk("ovf_not_busy", 32'(s_busy), 0);
        FIFO_Overflow = 1'b0; Drop_Clr = 1'b1;
        step();
        Drop_Clr = 1'b0;
        step();
        chk("drop_clr", 32'(s_drop), 0);

        // BIST holds everything; afterwards the held write goes before the pending read
        BIST_Mode = 1'b1; fifo_push(8'h40);
        Rx_Valid = 1'b1; Rx_Data = 8'h61; step();
        Rx_Valid = 1'b0; step();
        Rx_Valid = 1'b1; Rx_Data = 8'h62; step();
        Rx_Valid = 1'b0; Host_Rd_Req = 1'b1; cnt = 0;
        for (int k = 0; k < 6; k++) begin
            step();
            cnt += int'(s_rdy) + int'(s_pop);
        end
        chk("bist_no_strobe", 32'(cnt), 0);
        chk("bist_drop", 32'(s_drop), 1);
        BIST_Mode = 1'b0; rdy_i = -1; pop_i = -1; hack_i = -1; wr = 8'h00; d = 8'h00;
        for (int k = 0; k < 12; k++) begin
            step();
            if (s_rdy && rdy_i < 0) begin rdy_i = k; wr = s_wr; end
            if (s_pop && pop_i < 0) pop_i = k;
            if (s_hack && hack_i < 0) begin hack_i = k; d = s_rd; end
        end
        chk("bist_wr_first", 32'(rdy_i), 1);
        chk("bist_pop_after", 32'(pop_i), 4);
        chk("bist_wr_data", 32'(wr), 32'h61);
        chk("bist_ack_time", 32'(hack_i), 7);
        chk("bist_rd_data", 32'(d), 32'h40);

        // Round robin from a fresh reset (pointer at host), both requests held
        do_reset();
        auto_drop = 1'b0;
        fifo_push(8'h11); fifo_push(8'h22); fifo_push(8'h33);
        Host_Rd_Req = 1'b1; Loop_Rd_Req = 1'b1; n = 0;
        for (int k = 0; k < 40 && n < 3; k++) begin
            step();
            if (s_hack | s_lack) begin
                who[n] = s_lack; dat[n] = s_rd; n++;
            end
        end
        Host_Rd_Req = 1'b0; Loop_Rd_Req = 1'b0; auto_drop = 1'b1;
        chk("rr_count", 32'(n), 3);
        if (n == 3) begin
            chk("rr_order", 32'({who[0], who[1], who[2]}), 32'b010);
            chk("rr_data", 32'({dat[0], dat[1], dat[2]}), 32'h112233);
        end

        // Reset asserted in RD_STB
        fifo_push(8'h9A); Host_Rd_Req = 1'b1; found = 1'b0;
        for (int k = 0; k < 10 && !found; k++) begin
            @(negedge clk);
            if (FIFO_Pop_Data) found = 1'b1;
        end
        chk("rst_reach_rdstb", 32'(found), 1);
        rst = 1'b1;
        #1;
        chk("rst_pop_falls", 32'({FIFO_Pop_Data, Host_Rd_Ack, Busy}), 32'b001);
        Host_Rd_Req = 1'b0; fq.delete(); dout_next = 8'h00; FIFO_Empty = 1'b1; prev_strobe = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        cnt = 0; cnt2 = 0;
        for (int k = 0; k < 12; k++) begin
            step();
            cnt += int'(s_hack) + int'(s_lack);
            cnt2 += int'(s_pop) + int'(s_rdy);
        end
        chk("rst_no_ack", 32'(cnt), 0);
        chk("rst_no_strobe", 32'(cnt2), 0);

        // Randomized traffic against the scoreboard
        do_reset();
        sb_on = 1'b1;
        for (int c = 0; c < 1200; c++) begin
            Rx_Valid = ($urandom_range(0, 2) == 0);
            Rx_Data = 8'($urandom);
            if (!Host_Rd_Req && $urandom_range(0, 3) == 0) Host_Rd_Req = 1'b1;
            if (!Loop_Rd_Req && $urandom_range(0, 3) == 0) Loop_Rd_Req = 1'b1;
            if ($urandom_range(0, 15) == 0) BIST_Mode = ~BIST_Mode;
            Drop_Clr = ($urandom_range(0, 15) == 0);
            step();
        end
        Rx_Valid = 1'b0; BIST_Mode = 1'b0; Drop_Clr = 1'b0;
        for (int c = 0; c < 200 && (Host_Rd_Req || Loop_Rd_Req || exp_wr.size() > 0); c++) begin
            if (fq.size() == 0) fifo_push(8'($urandom));
            step();
        end
        chk("drain_reqs", 32'({Host_Rd_Req, Loop_Rd_Req}), 0);
        chk("drain_wr", 32'(exp_wr.size()), 0);
        chk("drain_rd", 32'(exp_rd.size()), 0);
        sb_on = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
